// File: rtl/stream_skid_buffer.sv
// Two-entry fall-through stream buffer: an arriving word is shown at once when empty, else queued behind the head.
// Latency 0 (write to read when empty); wr_ready stays high while a slot is free or the head is being taken.
module stream_skid_buffer #(
  parameter int W_D = 32
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           wr_valid,
  input  logic [W_D-1:0] wr_data,
  output logic           wr_ready,
  output logic           rd_valid,
  output logic [W_D-1:0] rd_data,
  input  logic           rd_ready,
  output logic [1:0]     count
);

  logic [W_D-1:0] head;
  logic [W_D-1:0] tail;
  logic           pop_buf;
  logic           store;

  assign rd_valid = (count != 2'd0) || wr_valid;
  assign rd_data  = (count == 2'd0) ? wr_data : head;
  assign wr_ready = (count != 2'd2) || rd_ready;
  assign pop_buf  = rd_ready && (count != 2'd0);
  // A word arriving at an empty buffer and taken the same cycle never needs a slot.
  assign store    = wr_valid && wr_ready && !((count == 2'd0) && rd_ready);

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({store, pop_buf})
        2'b10: begin
          if (count == 2'd0) head <= wr_data;
          else               tail <= wr_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= wr_data;
          end else begin
            head <= tail;
            tail <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instream_block_reader.sv
// Reads one block of block_len words from a CoramInStream port and streams them to the core with out_last/done.
// First word two cycles after start, then one per cycle; out_ready may stall any cycle, reads pause, nothing lost.
module instream_block_reader #(
  parameter int W_D   = 32,
  parameter int W_LEN = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [W_LEN-1:0] block_len,
  output logic             busy,
  output logic             done,
  input  logic [W_D-1:0]   fifo_q,
  input  logic             fifo_empty,
  output logic             fifo_deq,
  output logic [W_D-1:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [W_LEN-1:0] len;
  logic [W_LEN-1:0] issued;
  logic [W_LEN-1:0] delivered;
  logic             in_flight;
  logic [1:0]       buf_count;
  logic             buf_wr_ready;
  logic             accept;
  logic             last_word;
  logic             room;

  stream_skid_buffer #(.W_D(W_D)) u_buf (
    .CLK      (CLK),
    .RST      (RST),
    .wr_valid (in_flight),
    .wr_data  (fifo_q),
    .wr_ready (buf_wr_ready),
    .rd_valid (out_valid),
    .rd_data  (out_data),
    .rd_ready (out_ready),
    .count    (buf_count)
  );

  assign accept    = out_valid && out_ready;
  assign last_word = (delivered == len - W_LEN'(1));
  assign out_last  = out_valid && last_word;

  // A landing read already holds one of the two slots.
  assign room     = in_flight ? ((buf_count == 2'd0) || accept) : buf_wr_ready;
  assign fifo_deq = (state == RUN) && !fifo_empty && (issued < len) && room;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (block_len == '0) ? FIN : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (accept && last_word) state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      len       <= '0;
      issued    <= '0;
      delivered <= '0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= fifo_deq;
      if ((state == IDLE) && start) begin
        len       <= block_len;
        issued    <= '0;
        delivered <= '0;
      end else begin
        if (fifo_deq) issued    <= issued + W_LEN'(1);
        if (accept)   delivered <= delivered + W_LEN'(1);
      end
    end
  end

endmodule

// File: tb/tb_instream_block_reader.sv
// Bench for instream_block_reader: queue-based FIFO source, count-level reference model, directed and random blocks.
module tb_instream_block_reader;
  localparam int W_D   = 32;
  localparam int W_LEN = 32;
  localparam int P_IDLE = 0, P_RUN = 1, P_FIN = 2;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             start = 1'b0;
  logic [W_LEN-1:0] block_len = '0;
  logic             busy, done;
  logic [W_D-1:0]   fifo_q = '0;
  logic             fifo_empty = 1'b1;
  logic             fifo_deq;
  logic [W_D-1:0]   out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_last;

  always #5 CLK = ~CLK;

  instream_block_reader #(.W_D(W_D), .W_LEN(W_LEN)) dut (
    .CLK(CLK), .RST(RST), .start(start), .block_len(block_len), .busy(busy), .done(done),
    .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_deq(fifo_deq),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  int n_checks = 0, n_fail = 0, cyc = 0;
  bit chk_en = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Source FIFO and stimulus knobs
  logic [W_D-1:0] fifo_mem[$];
  logic [W_D-1:0] staged = '0;
  bit deq_stage = 0;
  int rdy_mode = 0, rcnt = 0;
  bit rnd_empty = 0, man_empty = 0, force_empty = 0;

  // Reference model: counts of words read and delivered in the current block
  int m_phase = P_IDLE;
  longint m_len = 0, m_issued = 0, m_deliv = 0, occ;
  logic [W_D-1:0] m_pend[$];
  bit e_valid, e_acc, e_deq, e_last;
  bit hold_prev = 0;
  logic [W_D-1:0] prev_data = '0;
  int dut_pend = 0;

  // Logs for directed checks
  int acc_cyc[$];
  logic [W_D-1:0] acc_dat[$];
  int deq_cnt = 0, done_cnt = 0, done_cyc = -1, start_cyc = -1, busy_cnt = 0, last_cyc = -1;

  initial begin
    forever begin
      @(negedge CLK); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = (rcnt % 3 == 0);
        default: out_ready = 1'($urandom_range(1, 0));
      endcase
      rcnt++;
      force_empty = rnd_empty ? ($urandom_range(3, 0) == 0) : man_empty;
    end
  end

  initial begin
    forever begin
      @(posedge CLK); #1;
      if (deq_stage) fifo_q = staged;
    end
  end

  initial begin
    forever begin
      @(negedge CLK); #2;
      fifo_empty = force_empty || (fifo_mem.size() == 0);
      #1;
      deq_stage = 0;
      if (chk_en) begin
        occ     = m_issued - m_deliv;
        e_valid = (m_phase == P_RUN) && (occ > 0);
        e_acc   = e_valid && out_ready;
        e_deq   = (m_phase == P_RUN) && !fifo_empty && (m_issued < m_len) && ((occ < 2) || e_acc);
        e_last  = e_valid && (m_deliv == m_len - 1);
        chk("busy", busy, m_phase != P_IDLE);
        chk("done", done, m_phase == P_FIN);
        chk("fifo_deq", fifo_deq, e_deq);
        chk("out_valid", out_valid, e_valid);
        chk("out_last", out_last, e_last);
        if (e_valid && m_pend.size() > 0) chk("out_data", out_data, m_pend[0]);
        if (hold_prev) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, prev_data);
        end
        chk("occ_le2", dut_pend <= 2, 1);
        if (out_valid && out_ready) begin
          acc_cyc.push_back(cyc);
          acc_dat.push_back(out_data);
          if (out_last) last_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (fifo_deq === 1'b1) begin
          deq_cnt++;
          chk("deq_nonempty", fifo_mem.size() != 0, 1);
          if (fifo_mem.size() != 0) begin
            staged = fifo_mem.pop_front();
            deq_stage = 1;
            m_pend.push_back(staged);
          end
        end
        hold_prev = out_valid && !out_ready && !RST;
        prev_data = out_data;
        if (RST) begin
          m_phase = P_IDLE; m_issued = 0; m_deliv = 0; m_pend.delete(); dut_pend = 0;
        end else begin
          dut_pend += int'(fifo_deq) - int'(out_valid && out_ready);
          case (m_phase)
            P_IDLE: if (start) begin
              m_len = longint'(block_len); m_issued = 0; m_deliv = 0; start_cyc = cyc;
              m_phase = (block_len == 0) ? P_FIN : P_RUN;
            end
            P_RUN: if (e_acc) begin
              if (m_pend.size() > 0) void'(m_pend.pop_front());
              m_deliv++;
              if (m_deliv == m_len) m_phase = P_FIN;
            end
            default: m_phase = P_IDLE;
          endcase
          if (e_deq) m_issued++;
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(negedge CLK); #1;
  endtask

  task automatic clear_logs();
    acc_cyc.delete(); acc_dat.delete();
    deq_cnt = 0; busy_cnt = 0; last_cyc = -1;
  endtask

  task automatic push_words(logic [W_D-1:0] base, int n, logic [W_D-1:0] stride);
    for (int i = 0; i < n; i++) fifo_mem.push_back(base + stride * W_D'(i));
  endtask

  task automatic issue(logic [W_LEN-1:0] len);
    start = 1'b1; block_len = len;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(int target, int budget, string name);
    int k = 0;
    while (done_cnt < target && k < budget) begin step(); k++; end
    chk(name, done_cnt >= target, 1);
  endtask

  task automatic wait_acc(int n, int budget, string name);
    int k = 0;
    while (acc_dat.size() < n && k < budget) begin step(); k++; end
    chk(name, acc_dat.size() >= n, 1);
  endtask

  int d0;
  logic [W_LEN-1:0] rlen;

  initial begin
    step(); step(); step();
    chk_en = 1;
    RST = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_deq", fifo_deq, 0);

    // 1: four words, full throughput
    rdy_mode = 0; clear_logs();
    fifo_mem.push_back(10); fifo_mem.push_back(20); fifo_mem.push_back(30); fifo_mem.push_back(40);
    d0 = done_cnt;
    issue(4);
    wait_done(d0 + 1, 50, "t1_done_timeout");
    step();
    chk("t1_count", acc_dat.size(), 4);
    if (acc_dat.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t1_data", acc_dat[i], 10 * (i + 1));
      chk("t1_first_latency", acc_cyc[0] - start_cyc, 2);
      chk("t1_back_to_back", acc_cyc[3] - acc_cyc[0], 3);
      chk("t1_last_cycle", last_cyc, acc_cyc[3]);
      chk("t1_done_cycle", done_cyc, acc_cyc[3] + 1);
    end
    chk("t1_deqs", deq_cnt, 4);

    // 2: 1,0,0 backpressure pattern
    rdy_mode = 1; rcnt = 0; clear_logs();
    push_words(32'h200, 8, 1);
    d0 = done_cnt;
    issue(8);
    wait_done(d0 + 1, 200, "t2_done_timeout");
    chk("t2_count", acc_dat.size(), 8);
    if (acc_dat.size() == 8) for (int i = 0; i < 8; i++) chk("t2_order", acc_dat[i], 32'h200 + i);

    // 3: words beyond the block stay for the next start
    rdy_mode = 0; clear_logs();
    push_words(1, 12, 1);
    d0 = done_cnt;
    issue(5);
    wait_done(d0 + 1, 60, "t3a_done_timeout");
    step(); step();
    chk("t3a_deqs", deq_cnt, 5);
    chk("t3a_left", fifo_mem.size(), 7);
    chk("t3a_last_word", acc_dat[acc_dat.size() - 1], 5);
    clear_logs();
    issue(7);
    wait_done(d0 + 2, 60, "t3b_done_timeout");
    chk("t3b_count", acc_dat.size(), 7);
    if (acc_dat.size() == 7) for (int i = 0; i < 7; i++) chk("t3b_data", acc_dat[i], 6 + i);

    // 4: zero-length block, then a start pulsed mid-block
    clear_logs();
    d0 = done_cnt;
    issue(0);
    wait_done(d0 + 1, 10, "t4_done_timeout");
    step(); step();
    chk("t4_busy_cycles", busy_cnt, 1);
    chk("t4_no_deq", deq_cnt, 0);
    chk("t4_no_words", acc_dat.size(), 0);
    rdy_mode = 1; rcnt = 0; clear_logs();
    push_words(32'h100, 5, 1);
    d0 = done_cnt;
    issue(3);
    step();
    issue(9);
    wait_done(d0 + 1, 60, "t4b_done_timeout");
    step(); step();
    chk("t4b_words", acc_dat.size(), 3);
    chk("t4b_left", fifo_mem.size(), 2);
    fifo_mem.delete();

    // 5: FIFO empty for three cycles mid-block
    rdy_mode = 0; clear_logs();
    push_words(32'h50, 6, 1);
    d0 = done_cnt;
    issue(6);
    wait_acc(2, 20, "t5_acc_timeout");
    man_empty = 1; step(); step(); step(); man_empty = 0;
    wait_done(d0 + 1, 60, "t5_done_timeout");
    chk("t5_count", acc_dat.size(), 6);
    if (acc_dat.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t5_data", acc_dat[i], 32'h50 + i);
      chk("t5_last", last_cyc, acc_cyc[5]);
    end

    // Maximum block length: never finishes on its own, no premature last
    clear_logs();
    push_words(32'hC0, 4, 1);
    issue({W_LEN{1'b1}});
    wait_acc(4, 30, "tmax_acc_timeout");
    step(); step();
    chk("tmax_busy", busy, 1);
    chk("tmax_deqs", deq_cnt, 4);
    chk("tmax_no_last", last_cyc, -1);

    // 6: reset mid-block, then a fresh short block
    RST = 1'b1; step(); RST = 1'b0;
    clear_logs();
    push_words(32'hE0, 8, 1);
    d0 = done_cnt;
    issue(8);
    wait_acc(3, 30, "t6_acc_timeout");
    RST = 1'b1;
    step();
    chk("t6_busy_after_rst", busy, 0);
    chk("t6_valid_after_rst", out_valid, 0);
    RST = 1'b0;
    step(); step();
    chk("t6_no_done", done_cnt, d0);
    fifo_mem.delete();
    clear_logs();
    fifo_mem.push_back(32'hA1); fifo_mem.push_back(32'hA2);
    issue(2);
    wait_done(d0 + 1, 30, "t6b_done_timeout");
    chk("t6b_count", acc_dat.size(), 2);
    if (acc_dat.size() == 2) begin
      chk("t6b_w0", acc_dat[0], 32'hA1);
      chk("t6b_w1", acc_dat[1], 32'hA2);
      chk("t6b_latency", acc_cyc[0] - start_cyc, 2);
      chk("t6b_done_cycle", done_cyc, acc_cyc[1] + 1);
    end

    // Random blocks with random backpressure and FIFO gaps
    for (int b = 0; b < 10; b++) begin
      rlen = W_LEN'($urandom_range(12, 1));
      rnd_empty = 1'($urandom_range(1, 0));
      rdy_mode = 2;
      while (fifo_mem.size() < int'(rlen) + int'($urandom_range(3, 0))) fifo_mem.push_back($urandom);
      d0 = done_cnt;
      issue(rlen);
      if ($urandom_range(1, 0) == 1 && busy) issue(W_LEN'($urandom_range(9, 0)));
      wait_done(d0 + 1, 600, "rnd_done_timeout");
      rnd_empty = 0;
      step();
    end

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
